// File: rtl/bus_memory_responder.sv
// ============================================================================
// bus_memory_responder : on-chip RAM bus slave with programmable wait states
// Revision 1.0
// ============================================================================
`default_nettype none

module bus_memory_responder #(
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
    parameter int          DEPTH_WORDS  = 1024,
    parameter int          WAIT_STATES  = 1,
    parameter int          TURNAROUND   = 2
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_bus_vaild,
    output logic        o_bus_ready,
    output logic        o_bus_busy,
    input  logic        i_bus_write_enable,
    input  logic [31:0] i_bus_address,
    output logic [31:0] o_bus_data_read,
    input  logic [31:0] i_bus_data_write
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LAST = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
    localparam logic [1:0]  TURN_LAST = 2'(TURNAROUND - 1);
    localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) << 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2,
        TURN = 2'd3
    } state_t;

    state_t      state, state_next;
    logic [3:0]  wait_count, wait_count_next;
    logic [1:0]  turn_count, turn_count_next;
    logic        accept, commit;

    logic          req_we, req_in_range;
    logic [AW-1:0] req_index;
    logic [31:0]   req_wdata;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0]   offset;
    logic          addr_in_range;
    logic [AW-1:0] addr_index;

    assign offset        = i_bus_address - BASE_ADDRESS;
    assign addr_in_range = (i_bus_address >= BASE_ADDRESS) && ({1'b0, offset} < SPAN);
    assign addr_index    = offset[AW+1:2];

    // With zero wait states the commit happens on the accept edge itself,
    // so the live bus fields must be used instead of the latched copy.
    logic          cur_we, cur_in_range;
    logic [AW-1:0] cur_index;
    logic [31:0]   cur_wdata;

    assign cur_we       = accept ? i_bus_write_enable : req_we;
    assign cur_in_range = accept ? addr_in_range      : req_in_range;
    assign cur_index    = accept ? addr_index         : req_index;
    assign cur_wdata    = accept ? i_bus_data_write   : req_wdata;

    always_comb begin
        state_next      = state;
        wait_count_next = wait_count;
        turn_count_next = turn_count;
        accept          = 1'b0;
        commit          = 1'b0;
        case (state)
            IDLE: begin
                if (i_bus_vaild) begin
                    accept          = 1'b1;
                    wait_count_next = 4'd0;
                    if (WAIT_STATES > 0) begin
                        state_next = WAIT;
                    end else begin
                        state_next = ACK;
                        commit     = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (wait_count == WAIT_LAST) begin
                    state_next = ACK;
                    commit     = 1'b1;
                end else begin
                    wait_count_next = wait_count + 4'd1;
                end
            end
            ACK: begin
                state_next      = TURN;
                turn_count_next = 2'd0;
            end
            TURN: begin
                if (turn_count == TURN_LAST) begin
                    state_next = IDLE;
                end else begin
                    turn_count_next = turn_count + 2'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state           <= IDLE;
            wait_count      <= 4'd0;
            turn_count      <= 2'd0;
            o_bus_ready     <= 1'b0;
            o_bus_busy      <= 1'b0;
            o_bus_data_read <= 32'h0;
        end else begin
            state       <= state_next;
            wait_count  <= wait_count_next;
            turn_count  <= turn_count_next;
            o_bus_ready <= (state_next == ACK);
            o_bus_busy  <= (state_next == WAIT);
            if (accept) begin
                req_we       <= i_bus_write_enable;
                req_in_range <= addr_in_range;
                req_index    <= addr_index;
                req_wdata    <= i_bus_data_write;
            end
            if (commit && !cur_we) begin
                o_bus_data_read <= cur_in_range ? mem[cur_index] : 32'h0;
            end
        end
    end

    // RAM is never cleared; reset only blocks a pending commit.
    always_ff @(posedge i_clock) begin
        if (!i_reset && commit && cur_we && cur_in_range) begin
            mem[cur_index] <= cur_wdata;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bus_memory_responder.sv
// ============================================================================
// tb_bus_memory_responder : directed self-checking bench for the RAM responder
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_bus_memory_responder;

    localparam logic [31:0] BASE  = 32'h0000_0100;
    localparam int          DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, valid_a, we_a, ready_a, busy_a;
    logic [31:0] addr_a, wdata_a, rdata_a;
    logic        rst_b, valid_b, we_b, ready_b, busy_b;
    logic [31:0] addr_b, wdata_b, rdata_b;

    bus_memory_responder #(
        .BASE_ADDRESS(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(2), .TURNAROUND(2)
    ) dut_a (
        .i_clock(clk), .i_reset(rst_a), .i_bus_vaild(valid_a),
        .o_bus_ready(ready_a), .o_bus_busy(busy_a),
        .i_bus_write_enable(we_a), .i_bus_address(addr_a),
        .o_bus_data_read(rdata_a), .i_bus_data_write(wdata_a)
    );

    bus_memory_responder #(
        .BASE_ADDRESS(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0), .TURNAROUND(2)
    ) dut_b (
        .i_clock(clk), .i_reset(rst_b), .i_bus_vaild(valid_b),
        .o_bus_ready(ready_b), .o_bus_busy(busy_b),
        .i_bus_write_enable(we_b), .i_bus_address(addr_b),
        .o_bus_data_read(rdata_b), .i_bus_data_write(wdata_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transaction; lat counts cycles from the accept edge to ready.
    task automatic txn(input bit sel, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rdata,
                       output int lat, output int busy_n, output logic busy_at_ready);
        lat = -1; busy_n = 0; busy_at_ready = 1'b1; rdata = 32'h0;
        if (sel) begin
            valid_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wdata;
        end else begin
            valid_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wdata;
        end
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (sel ? busy_b : busy_a) busy_n++;
            if (sel ? ready_b : ready_a) begin
                lat           = k;
                rdata         = sel ? rdata_b : rdata_a;
                busy_at_ready = sel ? busy_b : busy_a;
                break;
            end
        end
        valid_a = 1'b0;
        valid_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    logic [31:0] rd;
    logic        bar;
    int          lat, bn, n_ready, last, bad, stray;

    initial begin
        rst_a = 1'b1; valid_a = 1'b0; we_a = 1'b0; addr_a = 32'h0; wdata_a = 32'h0;
        rst_b = 1'b1; valid_b = 1'b0; we_b = 1'b0; addr_b = 32'h0; wdata_b = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready_a", 32'(ready_a), 32'h0);
        check("rst_busy_a",  32'(busy_a),  32'h0);
        check("rst_data_a",  rdata_a,      32'h0);
        check("rst_ready_b", 32'(ready_b), 32'h0);
        check("rst_busy_b",  32'(busy_b),  32'h0);
        check("rst_data_b",  rdata_b,      32'h0);
        rst_a = 1'b0; rst_b = 1'b0;
        @(posedge clk); #1;

        // Write / read back with two wait states
        txn(0, 1, BASE + 32'h10, 32'hDEAD_BEEF, rd, lat, bn, bar);
        check("wr_lat",        32'(lat), 32'd3);
        check("wr_busy_cnt",   32'(bn),  32'd2);
        check("wr_busy_ready", 32'(bar), 32'h0);
        txn(0, 0, BASE + 32'h10, 32'h0, rd, lat, bn, bar);
        check("rd_lat",  32'(lat), 32'd3);
        check("rd_data", rd,       32'hDEAD_BEEF);

        // Out of range accesses
        txn(0, 1, BASE, 32'hA5A5_0000, rd, lat, bn, bar);
        txn(0, 1, BASE + 32'(4 * DEPTH), 32'h1234, rd, lat, bn, bar);
        check("oor_wr_lat",  32'(lat), 32'd3);
        check("oor_wr_hold", rd,       32'hDEAD_BEEF);
        txn(0, 0, BASE + 32'(4 * DEPTH), 32'h0, rd, lat, bn, bar);
        check("oor_rd_lat",  32'(lat), 32'd3);
        check("oor_rd_data", rd,       32'h0);
        txn(0, 0, BASE, 32'h0, rd, lat, bn, bar);
        check("word0_kept",  rd,       32'hA5A5_0000);
        txn(0, 0, BASE - 32'h4, 32'h0, rd, lat, bn, bar);
        check("below_base",  rd,       32'h0);

        // Reset during wait states of a write
        txn(0, 1, BASE + 32'h20, 32'h1111_1111, rd, lat, bn, bar);
        txn(0, 0, BASE + 32'h20, 32'h0, rd, lat, bn, bar);
        check("pre_reset_data", rd, 32'h1111_1111);
        valid_a = 1'b1; we_a = 1'b1; addr_a = BASE + 32'h20; wdata_a = 32'h2222_2222;
        @(posedge clk); #1;
        check("busy_before_rst", 32'(busy_a), 32'h1);
        rst_a = 1'b1;
        @(posedge clk); #1;
        check("wrst_ready", 32'(ready_a), 32'h0);
        check("wrst_busy",  32'(busy_a),  32'h0);
        check("wrst_data",  rdata_a,      32'h0);
        rst_a = 1'b0; valid_a = 1'b0;
        stray = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (ready_a) stray++;
        end
        check("wrst_no_ready", 32'(stray), 32'h0);
        txn(0, 0, BASE + 32'h20, 32'h0, rd, lat, bn, bar);
        check("wrst_ram_kept", rd, 32'h1111_1111);

        // Byte-offset aliasing onto word 4
        txn(0, 1, BASE + 32'h13, 32'hCAFE_F00D, rd, lat, bn, bar);
        txn(0, 0, BASE + 32'h10, 32'h0, rd, lat, bn, bar);
        check("alias_data", rd, 32'hCAFE_F00D);

        // Valid held for 200 cycles: period 1+2+1+2 = 6, first ready at 3
        valid_a = 1'b1; we_a = 1'b0; addr_a = BASE + 32'h10;
        n_ready = 0; last = -1; bad = 0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            if (ready_a) begin
                if (last < 0 && k != 3) bad++;
                if (last >= 0 && (k - last) != 6) bad++;
                if (rdata_a !== 32'hCAFE_F00D) bad++;
                last = k;
                n_ready++;
            end
        end
        valid_a = 1'b0;
        check("held_ready_cnt", 32'(n_ready), 32'd33);
        check("held_spacing",   32'(bad),     32'd0);
        repeat (4) @(posedge clk);
        #1;

        // Zero wait states
        txn(1, 1, BASE + 32'h8, 32'h5A5A_0001, rd, lat, bn, bar);
        check("zw_wr_lat",  32'(lat), 32'd1);
        check("zw_wr_busy", 32'(bn),  32'd0);
        check("zw_wr_hold", rdata_b,  32'h0);
        txn(1, 0, BASE + 32'h8, 32'h0, rd, lat, bn, bar);
        check("zw_rd_lat",  32'(lat), 32'd1);
        check("zw_rd_busy", 32'(bn),  32'd0);
        check("zw_rd_data", rd,       32'h5A5A_0001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
